// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command decoder: FSM states,
// command codes, default framing bytes and a command-validity helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_CMD  = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4,
    S_EXEC = 3'd5,
    S_RESP = 3'd6
  } state_t;

  localparam logic [7:0] CMD_SET_X     = 8'h01;
  localparam logic [7:0] CMD_SET_Y     = 8'h02;
  localparam logic [7:0] CMD_SET_RGB   = 8'h03;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_SET_X) || (cmd == CMD_SET_Y) || (cmd == CMD_SET_RGB);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART FIFO handshake plus drawing-parameter outputs of the command decoder.
// master = decoder side, slave = UART/VGA side.
interface uart_cmd_decoder_if;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] rgb;
  logic        cmd_valid;
  logic        frame_err;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, wr_uart, w_data, xpos, ypos, rgb, cmd_valid, frame_err
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, wr_uart, w_data, xpos, ypos, rgb, cmd_valid, frame_err
  );
endinterface

// File: rtl/uart_cmd_decoder_timeout.sv
// Inter-byte timeout counter for partially received frames.
// Compiled only when UART_CMD_TIMEOUT_EN is defined.
`ifdef UART_CMD_TIMEOUT_EN
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_BITS     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic pop_i,
  output logic expire_o
);

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYC - 1);

  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;

  // Counter next-state: clear outside waiting states or on a pop, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || pop_i) begin
      cnt_d = {TO_BITS{1'b0}};
    end else if (cnt_q == TO_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(TO_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {TO_BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i & ~pop_i & (cnt_q == TO_LAST);

endmodule
`endif

// File: rtl/uart_cmd_decoder.sv
// Parses 5-byte UART command frames into registered X/Y/RGB values and answers ACK/NAK.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter int         TO_BITS     = 20
) (
  input logic               clk,
  input logic               reset,
  uart_cmd_decoder_if.master bus
);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [11:0] pay_q, pay_d;
  logic [7:0]  xor_q, xor_d;
  logic        chk_ok_q, chk_ok_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [11:0] rgb_q, rgb_d;
  logic [7:0]  resp_q, resp_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        wr_q, wr_d;
  logic [7:0]  w_data_q, w_data_d;

  logic        rd_s;
  logic        run_s;
  logic        timeout_s;
  logic        exec_ok_s;

  assign run_s     = (state_q == S_CMD) || (state_q == S_DHI) ||
                     (state_q == S_DLO) || (state_q == S_CHK);
  assign rd_s      = (run_s || (state_q == S_SYNC)) && !bus.rx_empty;
  assign exec_ok_s = chk_ok_q && is_known_cmd(cmd_q);

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_BITS     (TO_BITS)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .run_i    (run_s),
    .pop_i    (rd_s),
    .expire_o (timeout_s)
  );
`else
  logic [TO_BITS-1:0] unused_to_last_s;
  assign unused_to_last_s = TO_BITS'(TIMEOUT_CYC - 1);
  assign timeout_s        = 1'b0;
`endif

  // Frame FSM next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pay_d       = pay_q;
    xor_d       = xor_q;
    chk_ok_d    = chk_ok_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    rgb_d       = rgb_q;
    resp_d      = resp_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    wr_d        = 1'b0;
    w_data_d    = w_data_q;
    // A pop always wins over an expiring timeout in the same cycle.
    if (run_s && !rd_s && timeout_s) begin
      state_d     = S_SYNC;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_SYNC: begin
          if (rd_s && (bus.r_data == SYNC_BYTE)) state_d = S_CMD;
          else                                   state_d = S_SYNC;
        end
        S_CMD: begin
          if (rd_s) begin
            cmd_d   = bus.r_data;
            xor_d   = bus.r_data;
            state_d = S_DHI;
          end else begin
            state_d = S_CMD;
          end
        end
        S_DHI: begin
          if (rd_s) begin
            pay_d[11:8] = bus.r_data[3:0];
            xor_d       = xor_q ^ bus.r_data;
            state_d     = S_DLO;
          end else begin
            state_d = S_DHI;
          end
        end
        S_DLO: begin
          if (rd_s) begin
            pay_d[7:0] = bus.r_data;
            xor_d      = xor_q ^ bus.r_data;
            state_d    = S_CHK;
          end else begin
            state_d = S_DLO;
          end
        end
        S_CHK: begin
          if (rd_s) begin
            chk_ok_d = (xor_q == bus.r_data);
            state_d  = S_EXEC;
          end else begin
            state_d = S_CHK;
          end
        end
        S_EXEC: begin
          if (exec_ok_s) begin
            case (cmd_q)
              CMD_SET_X:   xpos_d = pay_q;
              CMD_SET_Y:   ypos_d = pay_q;
              CMD_SET_RGB: rgb_d  = pay_q;
              default:     xpos_d = xpos_q;
            endcase
            cmd_valid_d = 1'b1;
            resp_d      = ACK_BYTE;
          end else begin
            frame_err_d = 1'b1;
            resp_d      = NAK_BYTE;
          end
          state_d = S_RESP;
        end
        S_RESP: begin
          if (!bus.tx_full) begin
            wr_d     = 1'b1;
            w_data_d = resp_q;
            state_d  = S_SYNC;
          end else begin
            state_d = S_RESP;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_SYNC;
      cmd_q       <= 8'h00;
      pay_q       <= 12'h000;
      xor_q       <= 8'h00;
      chk_ok_q    <= 1'b0;
      xpos_q      <= 12'h000;
      ypos_q      <= 12'h000;
      rgb_q       <= 12'h000;
      resp_q      <= 8'h00;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_q        <= 1'b0;
      w_data_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pay_q       <= pay_d;
      xor_q       <= xor_d;
      chk_ok_q    <= chk_ok_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      rgb_q       <= rgb_d;
      resp_q      <= resp_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      wr_q        <= wr_d;
      w_data_q    <= w_data_d;
    end
  end

  assign bus.rd_uart   = rd_s & reset;
  assign bus.wr_uart   = wr_q;
  assign bus.w_data    = w_data_q;
  assign bus.xpos      = xpos_q;
  assign bus.ypos      = ypos_q;
  assign bus.rgb       = rgb_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule
